// File: rtl/atsc_rs_out_framer.sv
// Re-framer between the RS decoder output and the RFNoC AXI wrapper: programmable packet length,
// optional codeword flush, CHDR header rebuild and a skid-buffered output. Optional: RS_FRAMER_SEQNUM_EN.
module atsc_rs_out_framer #(
  parameter int DATA_W            = 32,
  parameter int MAX_PKT_WORDS     = 1024,
  parameter int DEFAULT_PKT_WORDS = 64,
  parameter int SR_PKT_LEN        = 130,
  parameter int SR_CTRL           = 131
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              clear_tx_seqnum,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [15:0]       src_sid,
  input  logic [15:0]       next_dst_sid,
  input  logic [127:0]      hdr_in,
  input  logic              hdr_in_stb,
  input  logic [DATA_W-1:0] dec_tdata,
  input  logic              dec_tvalid,
  input  logic              dec_tlast,
  output logic              dec_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic [127:0]      o_tuser,
  output logic              o_tvalid,
  output logic              o_tlast,
  input  logic              o_tready,
  output logic [31:0]       rb_pkt_count
);

  localparam int CNT_W = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [CNT_W-1:0] MAX_LEN     = CNT_W'(MAX_PKT_WORDS);
  localparam logic [CNT_W-1:0] DEFAULT_LEN = CNT_W'(DEFAULT_PKT_WORDS);

  typedef enum logic {IDLE, BODY} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count, pkt_len_reg, pkt_len_active, len_clamped;
  logic [CNT_W-1:0]  cur_len, cur_cnt;
  logic              flush_on_tlast;
  logic [127:0]      hdr_last, user_active, start_user, beat_user;
  logic [31:0]       payload_bytes, len_field;
  logic [11:0]       seq_field;
  logic              accept, beat_last;
  logic              skid_full, skid_last;
  logic [DATA_W-1:0] skid_data;
  logic [127:0]      skid_user;
  logic              unused_bits;

  // Ready depends only on the registered skid flag, so it never combinationally follows o_tready.
  assign dec_tready = ~skid_full & ~ce_rst;
  assign accept     = dec_tvalid & dec_tready;

  always_comb begin
    len_clamped = CNT_W'(set_data[15:0]);
    if (set_data[15:0] == 16'd0 || 32'(set_data[15:0]) > 32'(MAX_PKT_WORDS))
      len_clamped = MAX_LEN;
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      pkt_len_reg    <= DEFAULT_LEN;
      flush_on_tlast <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_PKT_LEN)) pkt_len_reg <= len_clamped;
      if (set_addr == 8'(SR_CTRL))    flush_on_tlast <= set_data[0];
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst)          hdr_last <= '0;
    else if (hdr_in_stb) hdr_last <= hdr_in;
  end

`ifdef RS_FRAMER_SEQNUM_EN
  logic [11:0] seqnum;

  // Sequence advances when a packet is framed, so the next header already sees the new value.
  always_ff @(posedge ce_clk) begin
    if (ce_rst)                   seqnum <= '0;
    else if (clear_tx_seqnum)     seqnum <= '0;
    else if (accept && beat_last) seqnum <= seqnum + 12'd1;
  end

  assign seq_field   = seqnum;
  assign unused_bits = ^{set_data[31:16], hdr_last[123:64], len_field[31:16]};
`else
  assign seq_field   = hdr_last[123:112];
  assign unused_bits = ^{clear_tx_seqnum, set_data[31:16], hdr_last[111:64], len_field[31:16]};
`endif

  assign payload_bytes = 32'(pkt_len_reg) * 32'(DATA_W / 8);
  assign len_field     = payload_bytes + 32'd8 + (hdr_last[125] ? 32'd8 : 32'd0);
  assign start_user    = {hdr_last[127:124], seq_field, len_field[15:0], src_sid, next_dst_sid,
                          hdr_last[63:0]};

  assign cur_len   = (state == IDLE) ? pkt_len_reg : pkt_len_active;
  assign cur_cnt   = (state == IDLE) ? '0 : count;
  assign beat_last = (cur_cnt == cur_len - 1'b1) | (flush_on_tlast & dec_tlast);
  assign beat_user = (state == IDLE) ? start_user : user_active;

  always_ff @(posedge ce_clk) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = beat_last ? IDLE : BODY;
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      count          <= '0;
      pkt_len_active <= DEFAULT_LEN;
      user_active    <= '0;
    end else if (accept) begin
      count <= beat_last ? '0 : cur_cnt + 1'b1;
      if (state == IDLE) begin
        pkt_len_active <= pkt_len_reg;
        user_active    <= start_user;
      end
    end
  end

  // Output register backed by a single skid entry that catches the beat accepted during a stall.
  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_tdata   <= '0;
      o_tuser   <= '0;
      skid_full <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      skid_user <= '0;
    end else if (!o_tvalid || o_tready) begin
      if (skid_full) begin
        o_tvalid  <= 1'b1;
        o_tlast   <= skid_last;
        o_tdata   <= skid_data;
        o_tuser   <= skid_user;
        skid_full <= 1'b0;
      end else if (accept) begin
        o_tvalid <= 1'b1;
        o_tlast  <= beat_last;
        o_tdata  <= dec_tdata;
        o_tuser  <= beat_user;
      end else begin
        o_tvalid <= 1'b0;
      end
    end else if (accept) begin
      skid_full <= 1'b1;
      skid_last <= beat_last;
      skid_data <= dec_tdata;
      skid_user <= beat_user;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst)                            rb_pkt_count <= '0;
    else if (o_tvalid && o_tready && o_tlast) rb_pkt_count <= rb_pkt_count + 32'd1;
  end

endmodule

// File: doc/atsc_rs_out_framer.md
# atsc_rs_out_framer

Parametrised re-framer between the HLS RS decoder core output and the AXI wrapper's `s_axis_data` input of an RFNoC computation engine. It replaces the fixed 256-byte payload override with:
- a register-programmable packet length;
- optional flush on the decoder's codeword boundary;
- locally generated CHDR sequence numbers and SIDs;
- a registered skid-buffered output with a readback packet counter.

Data width is generic, so the same block serves 32-bit and 64-bit decoder variants.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits; 32 or 64.
- `MAX_PKT_WORDS`, 1024: largest programmable packet length in words; power of two.
- `DEFAULT_PKT_WORDS`, 64: packet length loaded at reset.
- `SR_PKT_LEN`, 130: settings address for the packet length, `set_data[15:0]`.
- `SR_CTRL`, 131: settings address for control; bit0 = `flush_on_tlast`, reset value 0.

Ports:
- `ce_clk`, in, 1: clock.
- `ce_rst`, in, 1: reset, synchronous, active-high.
- `clear_tx_seqnum`, in, 1: synchronous clear of the sequence counter.
- `set_stb`, `set_addr`, `set_data`, in, 1/8/32: settings bus.
- `src_sid`, `next_dst_sid`, in, 16/16: SIDs inserted into the output header.
- `hdr_in`, in, 128: input packet header (tuser format); header word is `[127:64]`.
- `hdr_in_stb`, in, 1: `hdr_in` valid; pulses on the first accepted input beat.
- `dec_tdata`, in, `DATA_W`: decoder output data.
- `dec_tvalid`, `dec_tlast`, in, 1: decoder valid; decoder codeword end.
- `dec_tready`, out, 1: ready to decoder.
- `o_tdata`, out, `DATA_W`: framed output data.
- `o_tuser`, out, 128: framed output header.
- `o_tvalid`, `o_tlast`, out, 1: framed output valid and last.
- `o_tready`, in, 1: downstream ready.
- `rb_pkt_count`, out, 32: count of completed output packets.

## Operation
- **Header capture.** `hdr_in` is latched into `hdr_last` on `hdr_in_stb`; `hdr_last` resets to 0. The output header is built from `hdr_last` at packet start:
  - pkt_type, has_time and eob bits are copied.
  - `[111:96]` = payload_bytes + 8 + (has_time ? 8 : 0).
  - `[95:80]` = `src_sid`; `[79:64]` = `next_dst_sid`.
  - `[63:0]` time is copied.
- **FSM.**
  - IDLE → BODY on the first accepted decoder beat. At that beat `o_tuser` is frozen and `pkt_len_active` is loaded from `pkt_len_reg`.
  - BODY → IDLE on the beat carrying `o_tlast`.
- **Word counter.** The counter is `clog2(MAX_PKT_WORDS)+1` bits and counts beats within a packet. `o_tlast` asserts when count == `pkt_len_active`−1, or when `flush_on_tlast` is set and `dec_tlast` is high.
- **Payload length.** payload_bytes = `pkt_len_active`·`DATA_W`/8. A short flushed packet still carries the programmed length in `o_tuser`; the AXI wrapper's tlast governs the actual length.
- **`SR_PKT_LEN` writes.**
  - Value 0 or a value > `MAX_PKT_WORDS` is clamped to `MAX_PKT_WORDS`.
  - A write during BODY takes effect at the next packet start.
- **Sequence number.** 12-bit `seqnum`, incremented on each `o_tlast` beat, wrapping 4095 → 0. `clear_tx_seqnum` zeroes it; if it coincides with a tlast beat, the clear wins.
- **Packet counter.** `rb_pkt_count` increments on each `o_tlast` beat and wraps at 2^32. It is cleared only by reset.
- **Reset mid-packet.**
  - FSM returns to IDLE, counters and skid buffer are cleared, and in-flight data is dropped.
  - `pkt_len_reg` returns to `DEFAULT_PKT_WORDS`; `flush_on_tlast` returns to 0.

## Timing
- **Output register and skid buffer.**
  - Output is registered with a one-entry skid buffer.
  - Latency from `dec_tvalid`&`dec_tready` to `o_tvalid` is 1 cycle.
  - Full throughput: one beat per cycle while `o_tready`=1.
- **Decoder ready.** `dec_tready` = NOT skid_full. It is registered and deasserts the cycle after the skid buffer captures a stalled beat.
- **Output stability.** `o_tdata`, `o_tlast` and `o_tuser` hold stable while `o_tvalid`=1 and `o_tready`=0. `o_tuser` is constant for all beats of a packet.
- **Reset values.** `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_tuser`=0, `dec_tready`=0 during reset and 1 on the first cycle after reset, `rb_pkt_count`=0, `seqnum`=0.
- **Settings timing.** A settings write is visible in the register the cycle after `set_stb`.

## Configuration
- **`RS_FRAMER_SEQNUM_EN` defined:** header `[123:112]` = internal `seqnum`, per Operation.
- **`RS_FRAMER_SEQNUM_EN` undefined:**
  - header `[123:112]` is copied from `hdr_last`.
  - The sequence counter and `clear_tx_seqnum` logic are not built; `clear_tx_seqnum` is ignored.

## Test plan
- **Default length.** Reset, `DATA_W`=32, stream 200 beats, `o_tready`=1 → three packets of 64 beats with header length field 264, then 8 beats pending with no tlast; `rb_pkt_count`=3.
- **Flush mode.** Write `SR_CTRL`=1, `SR_PKT_LEN`=100; decoder sends a 47-beat codeword with `dec_tlast` on beat 47 → `o_tlast` on output beat 47; `rb_pkt_count` increments by 1.
- **Length write mid-packet.** Write `SR_PKT_LEN`=16 at beat 10 of a 64-beat packet → current packet ends at beat 64, next packet ends at beat 16; write 0 → next packets are `MAX_PKT_WORDS` long.
- **Backpressure.** Random `o_tready` at 30% duty → no data loss, no duplication, output stable while stalled, beat order identical to input.
- **Seqnum wrap and clear.** With `RS_FRAMER_SEQNUM_EN`, send 4097 packets → seqnum runs 0..4095 then 0; assert `clear_tx_seqnum` on a tlast beat → next seqnum is 0.
- **Reset mid-packet.** Assert `ce_rst` at beat 20 → cycle after reset `o_tvalid`=0 and counters are 0; the next packet is full length with the reset-default header.
